// File: rtl/alu_pkg.sv
// Shared constants for the ALU control sequencer: default widths, opcode map and FSM states.
package alu_pkg;

  localparam int DATA_W_DEF = 6;
  localparam int OP_W_DEF   = 3;

  localparam logic [2:0] OP_ADD     = 3'd0;
  localparam logic [2:0] OP_SUB     = 3'd1;
  localparam logic [2:0] OP_NOT     = 3'd2;
  localparam logic [2:0] OP_AND     = 3'd3;
  localparam logic [2:0] OP_OR      = 3'd4;
  localparam logic [2:0] OP_XOR     = 3'd5;
  localparam logic [2:0] OP_XNOR    = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OPERANDS,
    ST_EXECUTE,
    ST_WRITEBACK
  } state_e;

endpackage

// File: rtl/alu_regfile.sv
// Small register file: one write port, three combinational read ports (two operands, one debug).
module alu_regfile #(
  parameter int DATA_W = 6,
  parameter int NREGS  = 4,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign ra_data  = regs_q[ra_addr];
  assign rb_data  = regs_q[rb_addr];
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_control_unit.sv
// Control-side sequencer for the combinational ALU: accepts one instruction per handshake,
// drives operands/enables over fixed cycles, captures ALU_OUT and writes it back to rd.
module alu_control_unit
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = 4,
  parameter int REG_AW = 2,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [REG_AW-1:0] instr_ra,
  input  logic [REG_AW-1:0] instr_rb,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic              load_en,
  input  logic [REG_AW-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] IN1_i,
  output logic [DATA_W-1:0] IN2_i,
  output logic              IN1_en,
  output logic              IN2_en,
  output logic              OUT_EN,
  output logic [OP_W-1:0]   OpControl,
  input  logic [DATA_W-1:0] ALU_OUT,
  output logic              busy,
  output logic              done,
  output logic              illegal_op
);

  state_e            state_q, state_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] in1_q, in1_d, in2_q, in2_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              in_en_q, in_en_d, out_en_q, out_en_d;
  logic              done_q, done_d, illegal_q, illegal_d;

  logic              accept, load_ok, rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata, ra_data, rb_data;

  assign load_ok     = (state_q == ST_IDLE) && load_en;
  assign instr_ready = (state_q == ST_IDLE) && !load_en && !rst;
  assign accept      = instr_valid && instr_ready;

  assign rf_we    = load_ok || (state_q == ST_WRITEBACK);
  assign rf_waddr = (state_q == ST_WRITEBACK) ? rd_q : load_addr;
  assign rf_wdata = (state_q == ST_WRITEBACK) ? result_q : load_data;

  // Operands are fetched from the raw instruction fields on the accept edge, so the
  // registered ALU drives are already valid throughout OPERANDS (regs cannot change there).
  alu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .ra_addr  (instr_ra),
    .ra_data  (ra_data),
    .rb_addr  (instr_rb),
    .rb_data  (rb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    result_d  = result_q;
    in1_d     = '0;
    in2_d     = '0;
    op_d      = '0;
    in_en_d   = 1'b0;
    out_en_d  = 1'b0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (instr_op == OP_W'(OP_ILLEGAL)) begin
            illegal_d = 1'b1;
          end else begin
            state_d = ST_OPERANDS;
            rd_d    = instr_rd;
            in1_d   = ra_data;
            in2_d   = rb_data;
            op_d    = instr_op;
            in_en_d = 1'b1;
          end
        end
      end
      ST_OPERANDS: begin
        state_d  = ST_EXECUTE;
        in1_d    = in1_q;
        in2_d    = in2_q;
        op_d     = op_q;
        in_en_d  = 1'b1;
        out_en_d = 1'b1;
      end
      ST_EXECUTE: begin
        state_d  = ST_WRITEBACK;
        result_d = ALU_OUT;
        done_d   = 1'b1;
      end
      ST_WRITEBACK: state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rd_q      <= '0;
      result_q  <= '0;
      in1_q     <= '0;
      in2_q     <= '0;
      op_q      <= '0;
      in_en_q   <= 1'b0;
      out_en_q  <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      result_q  <= result_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      op_q      <= op_d;
      in_en_q   <= in_en_d;
      out_en_q  <= out_en_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign IN1_i      = in1_q;
  assign IN2_i      = in2_q;
  assign IN1_en     = in_en_q;
  assign IN2_en     = in_en_q;
  assign OUT_EN     = out_en_q;
  assign OpControl  = op_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign illegal_op = illegal_q;

endmodule
